// File: rtl/fp_pkg.sv
// Shared widths, guard-bit count and stage-register record for the pipelined FP adder.
// Also used by fp_adder_pipe (optional rounding via FP_ADDER_ROUND_EN).
package fp_pkg;
    localparam int EXP_W_DEF  = 4;
    localparam int FRAC_W_DEF = 8;
    localparam int GRS_W      = 3;

    // Width-independent control carried by every pipeline stage register.
    typedef struct packed {
        logic valid;
        logic sign;
    } stage_ctrl_t;
endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input yields W.
module fp_lzc #(
    parameter int W     = 12,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);
    // The highest set bit is visited last, so it decides the count.
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CNT_W'(W - 1 - i);
        end
    end
endmodule

// File: rtl/fp_adder_pipe.sv
// 3-stage FP adder (align / add / normalize); out_valid shows in the third cycle after the input cycle.
// Define FP_ADDER_ROUND_EN for round-to-nearest-even; otherwise guard/round/sticky are truncated.
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign1,
    input  logic              sign2,
    input  logic [EXP_W-1:0]  exp1,
    input  logic [EXP_W-1:0]  exp2,
    input  logic [FRAC_W-1:0] frac1,
    input  logic [FRAC_W-1:0] frac2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              ovf,
    output logic              unf
);
    localparam int MAG_W = FRAC_W + GRS_W;
    localparam int SUM_W = MAG_W + 1;
    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam int XW    = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    // The whole pipeline freezes while a result is presented and not taken.
    logic stall, advance;
    logic out_valid_q, out_valid_d;

    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = reset || !stall;

    // S1: sort by magnitude, align the smaller operand.
    logic              op1_big, sign_l;
    logic [EXP_W-1:0]  exp_l, exp_s, exp_diff;
    logic [FRAC_W-1:0] frac_l, frac_s;
    logic [MAG_W-1:0]  mag_s_al;
    logic [2*MAG_W-1:0] shift_wide;

    always_comb begin
        op1_big    = {exp1, frac1} >= {exp2, frac2};
        exp_l      = op1_big ? exp1 : exp2;
        exp_s      = op1_big ? exp2 : exp1;
        frac_l     = op1_big ? frac1 : frac2;
        frac_s     = op1_big ? frac2 : frac1;
        sign_l     = op1_big ? sign1 : sign2;
        exp_diff   = exp_l - exp_s;
        shift_wide = {frac_s, {GRS_W{1'b0}}, {MAG_W{1'b0}}} >> exp_diff;
        if (32'(exp_diff) >= 32'(MAG_W)) begin
            mag_s_al = {{(MAG_W-1){1'b0}}, |frac_s};
        end else begin
            mag_s_al = shift_wide[2*MAG_W-1:MAG_W]
                     | {{(MAG_W-1){1'b0}}, |shift_wide[MAG_W-1:0]};
        end
    end

    stage_ctrl_t      s1_ctrl_q, s1_ctrl_d;
    logic             s1_sub_q, s1_sub_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [MAG_W-1:0] s1_mag_l_q, s1_mag_l_d, s1_mag_s_q, s1_mag_s_d;

    always_comb begin
        s1_ctrl_d  = s1_ctrl_q;
        s1_sub_d   = s1_sub_q;
        s1_exp_d   = s1_exp_q;
        s1_mag_l_d = s1_mag_l_q;
        s1_mag_s_d = s1_mag_s_q;
        if (advance) begin
            s1_ctrl_d.valid = in_valid;
            s1_ctrl_d.sign  = sign_l;
            s1_sub_d        = sign1 ^ sign2;
            s1_exp_d        = exp_l;
            s1_mag_l_d      = {frac_l, {GRS_W{1'b0}}};
            s1_mag_s_d      = mag_s_al;
        end
    end

    // S2: magnitude add/subtract; the larger operand is first, so no borrow out.
    stage_ctrl_t      s2_ctrl_q, s2_ctrl_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic [SUM_W-1:0] s2_sum_q, s2_sum_d;

    always_comb begin
        s2_ctrl_d = s2_ctrl_q;
        s2_exp_d  = s2_exp_q;
        s2_sum_d  = s2_sum_q;
        if (advance) begin
            s2_ctrl_d = s1_ctrl_q;
            s2_exp_d  = s1_exp_q;
            s2_sum_d  = s1_sub_q ? ({1'b0, s1_mag_l_q} - {1'b0, s1_mag_s_q})
                                 : ({1'b0, s1_mag_l_q} + {1'b0, s1_mag_s_q});
        end
    end

    // S3: normalize. The counter spans the carry bit, so the left shift is one less.
    logic [CNT_W-1:0]  lzc_cnt, norm_sh;
    logic              carry, sum_zero, under, over;
    logic [MAG_W-1:0]  norm;
    logic [FRAC_W-1:0] frac_t;
    logic [XW-1:0]     exp_x;
`ifdef FP_ADDER_ROUND_EN
    logic              round_up;
    logic [FRAC_W:0]   frac_r;
`endif

    fp_lzc #(.W(SUM_W), .CNT_W(CNT_W)) u_lzc (
        .value (s2_sum_q),
        .count (lzc_cnt)
    );

    always_comb begin
        carry    = s2_sum_q[SUM_W-1];
        sum_zero = (s2_sum_q == '0);
        norm_sh  = lzc_cnt - CNT_W'(1);
        if (carry) begin
            norm  = {s2_sum_q[SUM_W-1:2], |s2_sum_q[1:0]};
            exp_x = XW'(s2_exp_q) + XW'(1);
        end else begin
            norm  = s2_sum_q[MAG_W-1:0] << norm_sh;
            exp_x = XW'(s2_exp_q) - XW'(norm_sh);
        end
        under  = !carry && !sum_zero && (XW'(norm_sh) > XW'(s2_exp_q));
        frac_t = FRAC_W'(norm >> GRS_W);
`ifdef FP_ADDER_ROUND_EN
        round_up = norm[GRS_W-1] & (norm[GRS_W-2] | norm[GRS_W-3] | norm[GRS_W]);
        frac_r   = {1'b0, frac_t} + (FRAC_W+1)'(round_up);
        if (frac_r[FRAC_W]) begin
            frac_t = frac_r[FRAC_W:1];
            exp_x  = exp_x + XW'(1);
        end else begin
            frac_t = frac_r[FRAC_W-1:0];
        end
`endif
        over = !sum_zero && !under && (exp_x > EXP_MAX);
    end

    logic              sign_out_q, sign_out_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic [FRAC_W-1:0] frac_out_q, frac_out_d;

    always_comb begin
        out_valid_d = out_valid_q;
        sign_out_d  = sign_out_q;
        exp_out_d   = exp_out_q;
        frac_out_d  = frac_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (advance) begin
            out_valid_d = s2_ctrl_q.valid;
            sign_out_d  = 1'b0;
            exp_out_d   = '0;
            frac_out_d  = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            if (under) begin
                unf_d = 1'b1;
            end else if (over) begin
                sign_out_d = s2_ctrl_q.sign;
                exp_out_d  = '1;
                frac_out_d = '1;
                ovf_d      = 1'b1;
            end else if (!sum_zero) begin
                sign_out_d = s2_ctrl_q.sign;
                exp_out_d  = exp_x[EXP_W-1:0];
                frac_out_d = frac_t;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ctrl_q   <= '0;
            s1_sub_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_mag_l_q  <= '0;
            s1_mag_s_q  <= '0;
            s2_ctrl_q   <= '0;
            s2_exp_q    <= '0;
            s2_sum_q    <= '0;
            out_valid_q <= 1'b0;
            sign_out_q  <= 1'b0;
            exp_out_q   <= '0;
            frac_out_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            s1_ctrl_q   <= s1_ctrl_d;
            s1_sub_q    <= s1_sub_d;
            s1_exp_q    <= s1_exp_d;
            s1_mag_l_q  <= s1_mag_l_d;
            s1_mag_s_q  <= s1_mag_s_d;
            s2_ctrl_q   <= s2_ctrl_d;
            s2_exp_q    <= s2_exp_d;
            s2_sum_q    <= s2_sum_d;
            out_valid_q <= out_valid_d;
            sign_out_q  <= sign_out_d;
            exp_out_q   <= exp_out_d;
            frac_out_q  <= frac_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sign_out  = sign_out_q;
    assign exp_out   = exp_out_q;
    assign frac_out  = frac_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Bench for fp_adder_pipe (EXP_W=4, FRAC_W=8); reference model works on exact integer values.
module tb_fp_adder_pipe;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int RES_W  = 15;

    logic clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic sign1, sign2, sign_out, ovf, unf;
    logic [EXP_W-1:0]  exp1, exp2, exp_out;
    logic [FRAC_W-1:0] frac1, frac2, frac_out;
    logic [RES_W-1:0]  obs;

    assign obs = {sign_out, exp_out, frac_out, ovf, unf};

    fp_adder_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
        .frac1(frac1), .frac2(frac2),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
        .ovf(ovf), .unf(unf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int out_count = 0;
    logic [RES_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Exact sum in units of 2^-FRAC_W, then normalize/truncate (or round) from scratch.
    function automatic logic [RES_W-1:0] model(input logic s1, input logic [EXP_W-1:0] e1, input logic [FRAC_W-1:0] f1,
                                               input logic s2, input logic [EXP_W-1:0] e2, input logic [FRAC_W-1:0] f2);
        longint v1  = longint'(f1) << e1;
        longint v2  = longint'(f2) << e2;
        longint sum = (s1 ? -v1 : v1) + (s2 ? -v2 : v2);
        logic   sg  = (sum < 0);
        longint mag = sg ? -sum : sum;
        longint fr;
        int len = 0;
        int e;
        for (int b = 0; b < 40; b++) if ((mag >> b) != 0) len = b + 1;
        e = len - FRAC_W;
        if (mag == 0) return '0;
        if (e < 0) return RES_W'(1);
        fr = mag >> e;
`ifdef FP_ADDER_ROUND_EN
        if (e > 0) begin
            longint rem  = mag - (fr << e);
            longint half = longint'(1) << (e - 1);
            if (rem > half || (rem == half && (fr & 1) != 0)) fr = fr + 1;
            if (fr == (longint'(1) << FRAC_W)) begin
                fr = fr >> 1;
                e  = e + 1;
            end
        end
`endif
        if (e > (1 << EXP_W) - 1) return {sg, {EXP_W{1'b1}}, {FRAC_W{1'b1}}, 2'b10};
        return {sg, EXP_W'(e), FRAC_W'(fr), 2'b00};
    endfunction

    // scoreboard: push on input transfer, pop and compare on output transfer
    logic [RES_W-1:0] held;
    logic held_v = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (held_v) check("stall_hold", 32'({out_valid, obs}), 32'({1'b1, held}));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 0);
                end else if (out_ready) begin
                    check("result", 32'(obs), 32'(exp_q.pop_front()));
                    out_count++;
                end
            end
            held_v = out_valid && !out_ready;
            held   = obs;
            if (in_valid && in_ready) exp_q.push_back(model(sign1, exp1, frac1, sign2, exp2, frac2));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s1, input int e1, input int f1, input logic s2, input int e2, input int f2);
        sign1 = s1; exp1 = EXP_W'(e1); frac1 = FRAC_W'(f1);
        sign2 = s2; exp2 = EXP_W'(e2); frac2 = FRAC_W'(f2);
    endtask

    task automatic rand_op();
        int e1 = $urandom_range(0, 15);
        int e2 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : e1 - $urandom_range(0, 2);
        if (e2 < 0) e2 = 0;
        drive(1'($urandom_range(0, 1)), e1, $urandom_range(128, 255),
              1'($urandom_range(0, 1)), e2, $urandom_range(128, 255));
    endtask

    // Single op into an idle pipeline with out_ready=1: exact latency and value.
    task automatic directed(input string tag, input logic s1, input int e1, input int f1,
                            input logic s2, input int e2, input int f2, input logic [RES_W-1:0] expv);
        drive(s1, e1, f1, s2, e2, f2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 0);
        step();
        check({tag, "_lat2"}, 32'(out_valid), 0);
        step();
        check({tag, "_lat3"}, 32'(out_valid), 1);
        check({tag, "_val"}, 32'(obs), 32'(expv));
    endtask

    logic [RES_W-1:0] exp37;
    initial begin
        #1_000_000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, cyc, base;
        bit dropped, pend;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step(); step();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'(obs), 0);
        reset = 1'b0;
        step();

        directed("underflow", 0, 1, 8'h80, 1, 0, 8'hC0, {1'b0, 4'd0, 8'h00, 2'b01});
        directed("carry", 0, 3, 8'h80, 0, 3, 8'h80, {1'b0, 4'd4, 8'h80, 2'b00});
        directed("overflow", 0, 15, 8'h80, 0, 15, 8'h80, {1'b0, 4'd15, 8'hFF, 2'b10});
`ifdef FP_ADDER_ROUND_EN
        exp37 = {1'b0, 4'd1, 8'hC2, 2'b00};
`else
        exp37 = {1'b0, 4'd1, 8'hC1, 2'b00};
`endif
        directed("rounding", 0, 1, 8'h81, 0, 0, 8'h81, exp37);
        directed("cancel_zero", 0, 5, 8'hA0, 1, 5, 8'hA0, '0);
        directed("larger_sign", 1, 3, 8'h90, 0, 2, 8'hF0, {1'b1, 4'd0, 8'hC0, 2'b00});
        directed("tie_neg", 1, 2, 8'h80, 1, 2, 8'h80, {1'b1, 4'd3, 8'h80, 2'b00});
        directed("sticky_only", 0, 15, 8'h80, 0, 0, 8'hFF, model(0, 15, 8'h80, 0, 0, 8'hFF));
        directed("shift_11", 1, 11, 8'h80, 0, 0, 8'hFF, model(1, 11, 8'h80, 0, 0, 8'hFF));
        directed("sub_near", 0, 7, 8'hC3, 1, 6, 8'hFF, model(0, 7, 8'hC3, 1, 6, 8'hFF));
        step();

        // reset overrides a stalled output and forces in_ready high
        out_ready = 1'b0;
        drive(0, 2, 8'h90, 0, 1, 8'hA0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        step(); step();
        check("stall_in_ready", 32'(in_ready), 0);
        reset = 1'b1;
        #1;
        check("rst_stall_in_ready", 32'(in_ready), 1);
        step();
        check("rst_clears_valid", 32'(out_valid), 0);
        reset = 1'b0; out_ready = 1'b1;

        // reset with two operations in flight
        drive(0, 4, 8'hB0, 0, 4, 8'hC0);
        in_valid = 1'b1; step();
        drive(1, 6, 8'hF0, 0, 3, 8'h88);
        step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 0);
        reset = 1'b0;
        directed("after_rst", 0, 9, 8'hE1, 1, 8, 8'h9F, model(0, 9, 8'hE1, 1, 8, 8'h9F));
        step();

        // backpressure: 5 back-to-back inputs, out_ready low for 6 cycles
        sent = 0; cyc = 0; dropped = 0; base = out_count;
        while ((sent < 5 || exp_q.size() != 0) && cyc < 60) begin
            out_ready = (cyc >= 6);
            if (sent < 5) begin
                drive(0, 3 + sent, 8'h80 + 8'(sent * 17), sent[0], 2 + sent, 8'hC0 + 8'(sent));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!in_ready) dropped = 1'b1;
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_in_ready_dropped", 32'(dropped), 1);
        check("bp_result_count", 32'(out_count - base), 5);
        check("bp_in_time", 32'(cyc < 60), 1);

        // random traffic with random backpressure
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                rand_op();
                pend = 1'b1;
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) pend = 1'b0;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_adder_pipe.md
FP_ADDER_PIPE -- requirements
Module: fp_adder_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter EXP_W, default 4, SHALL set the unsigned exponent width.
REQ-003 Parameter FRAC_W, default 8, SHALL set the fraction width; a normalized fraction has MSB=1, value = 0.frac x 2^exp.
REQ-004 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-005 Port reset, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1) SHALL form the input handshake.
REQ-007 Ports sign1 and sign2 (input, 1) SHALL carry the operand signs; 1 = negative.
REQ-008 Ports exp1 and exp2 (input, EXP_W) SHALL carry the operand exponents.
REQ-009 Ports frac1 and frac2 (input, FRAC_W) SHALL carry the operand fractions.
REQ-010 Ports out_valid (output, 1) and out_ready (input, 1) SHALL form the output handshake.
REQ-011 Ports sign_out (output, 1), exp_out (output, EXP_W) and frac_out (output, FRAC_W) SHALL carry the result.
REQ-012 Port ovf (output, 1) SHALL flag exponent overflow; port unf (output, 1) SHALL flag underflow-to-zero; both are valid with out_valid.

Function
REQ-013 A transfer SHALL occur on each edge where valid and ready are both 1.
REQ-014 The datapath SHALL be a 3-stage pipeline, with a valid bit per stage. S1: sort by magnitude and align the smaller fraction right by the exponent difference, keeping guard, round and sticky bits. S2: add or subtract the magnitudes. S3: normalize.
REQ-015 The latency SHALL be 3 cycles from input transfer to out_valid; throughput SHALL be 1 result per cycle while out_ready=1.
REQ-016 Stall rule: in_ready SHALL equal !(out_valid && !out_ready). When stalled, all stages, out_valid and the result ports SHALL hold stable.
REQ-017 When the exponents are equal and the fractions are equal, S1 SHALL take operand 1 as the larger; sign_out SHALL be the sign of the larger magnitude.
REQ-018 An alignment shift of FRAC_W+3 or more SHALL reduce the smaller operand to sticky only.
REQ-019 On a carry-out, S3 SHALL shift right by 1 and increment the exponent.
REQ-020 If the sum is not zero, S3 SHALL shift left by the leading-zero count and subtract that count from the exponent.
REQ-021 A zero sum SHALL give sign_out=0, exp_out=0, frac_out=0 and unf=0.
REQ-022 If the leading-zero count exceeds the larger exponent, the result SHALL be 0 with sign_out=0 and unf=1.
REQ-023 If the exponent exceeds 2^EXP_W-1, the result SHALL saturate to exp_out=all ones and frac_out=all ones, with ovf=1 and the sign kept.
REQ-024 Without rounding, the guard, round and sticky bits SHALL be dropped (truncation).

Reset
REQ-025 Reset SHALL clear all stage valid bits and SHALL set out_valid=0, sign_out=0, exp_out=0, frac_out=0, ovf=0 and unf=0.
REQ-026 While reset is asserted, in_ready SHALL be 1.
REQ-027 Reset mid-operation SHALL discard all in-flight operations, and no result for them SHALL appear afterwards.
REQ-028 Reset SHALL take priority over the handshake on the same edge.

Configuration
REQ-029 With macro FP_ADDER_ROUND_EN defined, S3 SHALL round to nearest, ties to even, using the guard, round and sticky bits.
REQ-030 With FP_ADDER_ROUND_EN defined, a rounding carry SHALL renormalize the fraction and increment the exponent, with the overflow rule applied.
REQ-031 Without FP_ADDER_ROUND_EN, results SHALL be truncated and latency SHALL be unchanged.

Structure
REQ-032 A shared package fp_pkg SHALL hold the default widths, the guard-bit count (3) and the stage-register record type.
REQ-033 One sub-module, fp_lzc (a parametrised leading-zero counter, FRAC_W+4 bits wide), SHALL be used in S3.

Verification (EXP_W=4, FRAC_W=8)
REQ-034 Underflow: inputs +(1,1000_0000) and -(0,1100_0000) SHALL produce, 3 cycles later, sign 0, exp 0, frac 0 and unf=1.
REQ-035 Carry: inputs +(3,1000_0000) and +(3,1000_0000) SHALL produce +(4,1000_0000) with ovf=0.
REQ-036 Overflow: inputs +(15,1000_0000) and +(15,1000_0000) SHALL produce +(15,1111_1111) with ovf=1.
REQ-037 Rounding: inputs +(1,1000_0001) and +(0,1000_0001) SHALL produce frac 1100_0010 with FP_ADDER_ROUND_EN and frac 1100_0001 without it, exp 1 in both cases.
REQ-038 Backpressure: with 5 back-to-back inputs and out_ready held 0 for 6 cycles, in_ready SHALL drop once a result is held, no result SHALL be lost or duplicated, and results SHALL appear in order.
REQ-039 Reset mid-stream: reset for 1 cycle with 2 operations in flight SHALL give out_valid=0 until the next input's result arrives 3 cycles after its transfer.
